// File: rtl/hex_display_scanner_pkg.sv
// Shared constants for the seven-segment scanner: segment table, encoder helper
// and an elaboration-time parameter legality check.
`ifndef HEX_DISPLAY_SCANNER_PKG_SV
`define HEX_DISPLAY_SCANNER_PKG_SV

`define HDS_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package hex_display_scanner_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp, g..a} patterns with the decimal point off.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] seg_hex(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

`endif

// File: rtl/hex_display_scanner_seg7_hex_encode.sv
// Combinational hex-to-segment encoder: nibble plus decimal point to an
// active-low {dp, g..a} byte.
module seg7_hex_encode
    import hex_display_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Table bytes carry dp=1 (off); clearing bit 7 lights the point.
    assign seg_o = seg_hex(nibble_i) & {~dp_i, 7'h7F};

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode seven-segment driver with shadow register,
// per-slot blanking window and optional leading-zero suppression.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [IDX_W-1:0]        scan_idx
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_POL = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    `HDS_PARAM_CHECK(chk_num_digits, (NUM_DIGITS >= 1 && NUM_DIGITS <= 8), "NUM_DIGITS must be 1..8")
    `HDS_PARAM_CHECK(chk_scan_div, (SCAN_DIV >= 2), "SCAN_DIV must be >= 2")
    `HDS_PARAM_CHECK(chk_blank, (BLANK_CYCLES >= 0 && BLANK_CYCLES < SCAN_DIV), "BLANK_CYCLES must be 0..SCAN_DIV-1")

    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic                  lit;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_supp;
    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;
    logic [7:0]            enc_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            cnt_q        <= '0;
            scan_idx_q   <= '0;
            seg_q        <= SEG_OFF;
            digit_sel_q  <= DIG_POL;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            cnt_q        <= cnt_d;
            scan_idx_q   <= scan_idx_d;
            seg_q        <= seg_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        scan_idx_d = scan_idx_q;
        if (enable) begin
            if (cnt_q == DIV_LAST) begin
                cnt_d      = '0;
                scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (shadow_val_q[4*i +: 4] == 4'h0);
            supp[i]  = blank_lz & zero_run & (i != 0);
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_supp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_nibble = shadow_val_q[4*i +: 4];
                cur_dp     = shadow_dp_q[i];
                cur_supp   = supp[i];
            end
        end
    end

    seg7_hex_encode u_encode (
        .nibble_i (cur_nibble),
        .dp_i     (cur_dp),
        .seg_o    (enc_seg)
    );

    always_comb begin
        lit         = enable && (cnt_q >= BLANK_END);
        digit_sel_d = DIG_POL;
        seg_d       = SEG_OFF;
        if (lit) begin
            digit_sel_d = (NUM_DIGITS'(1) << scan_idx_q) ^ DIG_POL;
            if (!cur_supp) begin
                seg_d = enc_seg;
            end
        end
    end

    assign seg       = seg_q;
    assign digit_sel = digit_sel_q;
    assign scan_idx  = scan_idx_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner at SCAN_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=4.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [3:0]  digit_sel;
    logic [1:0]  scan_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Active-low digit selects for digits 0..3.
    logic [3:0] dsel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    hex_display_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLANK_CYCLES   (1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .digit_sel (digit_sel),
        .scan_idx  (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        value_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        step(); step();
        n_checks++;
        if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want FF", seg); end
        n_checks++;
        if (digit_sel !== 4'hF) begin n_fail++; $display("FAIL reset_dsel: got %h want F", digit_sel); end
        n_checks++;
        if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", scan_idx); end
    endtask

    // Blank shadow: dark cycle then three cycles of C0 per slot, selects E,D,B,7.
    task automatic test_scan();
        logic [3:0] exp_dig [16] = '{4'hF,4'hE,4'hE,4'hE, 4'hF,4'hD,4'hD,4'hD,
                                     4'hF,4'hB,4'hB,4'hB, 4'hF,4'h7,4'h7,4'h7};
        logic [1:0] exp_idx [16] = '{2'd0,2'd0,2'd0,2'd1, 2'd1,2'd1,2'd1,2'd2,
                                     2'd2,2'd2,2'd2,2'd3, 2'd3,2'd3,2'd3,2'd0};
        logic [7:0] exp_seg;
        reset = 1'b0; enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            exp_seg = (k % 4 == 0) ? 8'hFF : 8'hC0;
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg[%0d]: got %h want %h", k, seg, exp_seg); end
            n_checks++;
            if (digit_sel !== exp_dig[k]) begin n_fail++; $display("FAIL scan_dsel[%0d]: got %h want %h", k, digit_sel, exp_dig[k]); end
            n_checks++;
            if (scan_idx !== exp_idx[k]) begin n_fail++; $display("FAIL scan_idx[%0d]: got %0d want %0d", k, scan_idx, exp_idx[k]); end
        end
    endtask

    // Load on the dark edge of slot 0, then watch the full scan.
    task automatic test_value_dp();
        logic [7:0] exp_tab [4] = '{8'h8E, 8'hA4, 8'h08, 8'hF9};
        logic [7:0] exp_seg;
        logic [3:0] exp_dsel;
        value_in = 16'h1A2F; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        for (int j = 1; j < 16; j++) begin
            step();
            exp_seg  = (j % 4 == 0) ? 8'hFF : exp_tab[j / 4];
            exp_dsel = (j % 4 == 0) ? 4'hF : dsel_tab[j / 4];
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL value_seg[%0d]: got %h want %h", j, seg, exp_seg); end
            n_checks++;
            if (digit_sel !== exp_dsel) begin n_fail++; $display("FAIL value_dsel[%0d]: got %h want %h", j, digit_sel, exp_dsel); end
        end
    endtask

    task automatic test_lz();
        logic [7:0]  exp_tab [2][4] = '{'{8'hC0, 8'hF8, 8'hFF, 8'hFF},
                                        '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
        logic [15:0] vals [2] = '{16'h0070, 16'h0000};
        logic [7:0]  exp_seg;
        logic [3:0]  exp_dsel;
        blank_lz = 1'b1; dp_in = 4'h0;
        for (int p = 0; p < 2; p++) begin
            value_in = vals[p]; load = 1'b1;
            step();
            load = 1'b0;
            for (int j = 1; j < 16; j++) begin
                step();
                exp_seg  = (j % 4 == 0) ? 8'hFF : exp_tab[p][j / 4];
                exp_dsel = (j % 4 == 0) ? 4'hF : dsel_tab[j / 4];
                n_checks++;
                if (seg !== exp_seg) begin n_fail++; $display("FAIL lz_seg[%0d][%0d]: got %h want %h", p, j, seg, exp_seg); end
                n_checks++;
                if (digit_sel !== exp_dsel) begin n_fail++; $display("FAIL lz_dsel[%0d][%0d]: got %h want %h", p, j, digit_sel, exp_dsel); end
            end
        end
        blank_lz = 1'b0;
    endtask

    // Shadow holds 0000 with suppression off; load FFFF while digit 1 is lit.
    task automatic test_midslot_load();
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (seg !== 8'hC0 || digit_sel !== 4'hD) begin
            n_fail++; $display("FAIL mid_pre: got seg %h dsel %h want C0 D", seg, digit_sel);
        end
        value_in = 16'hFFFF; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (seg !== 8'hC0) begin n_fail++; $display("FAIL mid_edge1: got %h want C0", seg); end
        step();
        n_checks++;
        if (seg !== 8'h8E) begin n_fail++; $display("FAIL mid_edge2: got %h want 8E", seg); end
        n_checks++;
        if (digit_sel !== 4'hD || scan_idx !== 2'd2) begin
            n_fail++; $display("FAIL mid_timing: got dsel %h idx %0d want D 2", digit_sel, scan_idx);
        end
        for (int j = 8; j < 16; j++) begin
            step();
            n_checks++;
            if (digit_sel !== ((j % 4 == 0) ? 4'hF : dsel_tab[j / 4])) begin
                n_fail++; $display("FAIL mid_dsel[%0d]: got %h", j, digit_sel);
            end
            n_checks++;
            if (seg !== ((j % 4 == 0) ? 8'hFF : 8'h8E)) begin
                n_fail++; $display("FAIL mid_seg[%0d]: got %h", j, seg);
            end
        end
    endtask

    task automatic test_enable();
        step(); step();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (seg !== 8'hFF || digit_sel !== 4'hF || scan_idx !== 2'd0) begin
                n_fail++; $display("FAIL en_off[%0d]: got seg %h dsel %h idx %0d want FF F 0", k, seg, digit_sel, scan_idx);
            end
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (seg !== 8'h8E || digit_sel !== 4'hE || scan_idx !== 2'd0) begin
            n_fail++; $display("FAIL en_resume0: got seg %h dsel %h idx %0d want 8E E 0", seg, digit_sel, scan_idx);
        end
        step();
        n_checks++;
        if (seg !== 8'h8E || digit_sel !== 4'hE || scan_idx !== 2'd1) begin
            n_fail++; $display("FAIL en_resume1: got seg %h dsel %h idx %0d want 8E E 1", seg, digit_sel, scan_idx);
        end
        step();
        n_checks++;
        if (seg !== 8'hFF || digit_sel !== 4'hF) begin
            n_fail++; $display("FAIL en_resume2: got seg %h dsel %h want FF F", seg, digit_sel);
        end
        step();
        n_checks++;
        if (digit_sel !== 4'hD) begin n_fail++; $display("FAIL en_resume3: got %h want D", digit_sel); end
    endtask

    // Mid-scan reset, then confirm shadow cleared and scan restarted at digit 0.
    task automatic test_mid_reset();
        step(); step();
        reset = 1'b1;
        step();
        n_checks++;
        if (seg !== 8'hFF || digit_sel !== 4'hF || scan_idx !== 2'd0) begin
            n_fail++; $display("FAIL mreset: got seg %h dsel %h idx %0d want FF F 0", seg, digit_sel, scan_idx);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (seg !== 8'hFF || digit_sel !== 4'hF) begin
            n_fail++; $display("FAIL mreset_dark: got seg %h dsel %h want FF F", seg, digit_sel);
        end
        step();
        n_checks++;
        if (seg !== 8'hC0 || digit_sel !== 4'hE || scan_idx !== 2'd0) begin
            n_fail++; $display("FAIL mreset_restart: got seg %h dsel %h idx %0d want C0 E 0", seg, digit_sel, scan_idx);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_value_dp();
        test_lz();
        test_midslot_load();
        test_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed driver for a bank of common-anode seven-segment digits on the board.
- Latches a packed hex value and per-digit decimal points into a shadow register.
- Scans one digit at a time at a parametrised rate, with an anti-ghosting blank window at each slot start.
- Optional leading-zero suppression.
- Sits between the debug/status register logic and the display pins; supersedes per-digit combinational decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
SCAN_DIV, 50000, clk cycles per digit slot (legal >= 2)
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (legal 0..SCAN_DIV-1)
DIG_ACTIVE_LOW, 1, 1 = digit_sel active-low, 0 = active-high

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
enable  in  1  1 = scanning; 0 = display dark, counters held
load  in  1  1-cycle strobe; captures value_in/dp_in into shadow
value_in  in  4*NUM_DIGITS  packed nibbles; nibble i = digit i, digit 0 least significant
dp_in  in  NUM_DIGITS  1 = decimal point lit on digit i
blank_lz  in  1  1 = suppress leading zeros
seg  out  8  active-low segments, bit7 = DP, bits6..0 = g..a
digit_sel  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW
scan_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the digit currently in its slot

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - shadow value and dp = 0; prescaler cnt = 0; scan_idx = 0
  - seg = 8'hFF
  - digit_sel = all inactive (all 1s if DIG_ACTIVE_LOW, else all 0s)
  - Reset mid-slot behaves identically.
- Shadow: on load=1, shadow <= value_in/dp_in at the next edge. Load is accepted regardless of enable. Without load, the shadow holds.
- Prescaler, when enable=1:
  - cnt increments each cycle.
  - When cnt == SCAN_DIV-1: cnt <= 0 and scan_idx <= (scan_idx == NUM_DIGITS-1) ? 0 : scan_idx+1.
- enable=0: cnt and scan_idx hold; the registered outputs go to the off state at the next edge.
- Output registers, updated every cycle:
  - lit = enable && cnt >= BLANK_CYCLES (current cnt, scan_idx)
  - digit_sel <= lit ? onehot(scan_idx) (polarity applied) : all inactive
  - seg <= (lit && !suppressed(scan_idx)) ? {~dp[scan_idx], enc(nibble[scan_idx])} : 8'hFF
- Latency:
  - Outputs lag the cnt/scan_idx state by 1 cycle.
  - load at edge t makes the shadow valid after t; seg reflects the new value after edge t+1.
  - A load mid-slot updates the current digit without waiting for a slot change.
- Leading-zero suppression: digit i (i >= 1) is suppressed iff blank_lz=1 and shadow nibbles NUM_DIGITS-1 down to i are all 0. Digit 0 is never suppressed.
  - A suppressed digit shows seg = 8'hFF, DP off too.
  - digit_sel still follows the scan, so brightness stays uniform.
- enc (active-low, g..a): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E. With DP off, the full byte is C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- NUM_DIGITS = 1: scan_idx is constantly 0 and the slot still repeats with its blank window.
- BLANK_CYCLES = 0: the digit is lit for the whole slot.
- Simultaneous load and slot wrap: both take effect. The new digit shows the new value one cycle later.

Decomposition:
- Shared package holds:
  - SEG_OFF = 8'hFF
  - the 16-entry SEG_HEX constant table (DP-off bytes above)
  - function seg_hex(nibble)
  - a parameter legality check macro
- One sub-module: seg7_hex_encode. Combinational: nibble + dp -> 8-bit active-low pattern, built on the package table. The scanner instantiates it once on the muxed nibble.

Test Plan:
- Run all tests with SCAN_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=4.
- Reset, then enable=1 with no load -> seg=FF/digit_sel=F at reset. After that, each 4-cycle slot shows 1 dark cycle, then 3 cycles of seg=C0. digit_sel cycles E,D,B,7 (active-low), and scan_idx wraps 3->0.
- load value_in=16'h1A2F, dp_in=4'b0100 -> digit 0 F:8E, digit 1 2:A4, digit 2 A:08 (DP lit), digit 3 1:F9.
- blank_lz=1, load 16'h0070 -> digits 3 and 2 give seg=FF, digit 1 gives F8, digit 0 gives C0. Load 16'h0000 -> only digit 0 lit, showing C0.
- Mid-slot load of 16'hFFFF while digit 1 is lit -> seg changes to 8E exactly 2 edges after the load strobe, and scan timing is unchanged.
- Deassert enable mid-slot for 5 cycles -> next edge seg=FF and digit_sel all inactive. cnt and scan_idx are frozen and resume from the same values when enable returns.
- Assert reset mid-scan with enable=1 -> next edge all outputs at reset values, shadow=0, scan restarts at digit 0.
